// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - shift-add multiply sequencer owning the register file write port
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  input  logic             wb_we,
  input  logic [31:0]      wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             wb_stall,
  output logic             rf_write_enable,
  output logic [1:0]       rf_mul,
  output logic [31:0]      rf_write_address,
  output logic [WIDTH-1:0] rf_write_data_1,
  output logic [WIDTH-1:0] rf_write_data_2
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_MADD  = 2'b10;
  localparam logic [1:0] OP_MULTU = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;       // multiplicand (raw, then magnitude)
  logic [WIDTH-1:0]   b_q, b_d;       // multiplier, shifted right each step
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     sum;            // upper half plus carry out of the add

  // Next-state and datapath: one partial product per RUN cycle, sign fixed up afterwards
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    case (state_q)
      S_IDLE: begin
        if (start && op != 2'b00) begin
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        // Magnitudes are kept unsigned so |0x80000000| = 2^31 fits without overflow
        if (op_q == OP_MULTU) begin
          neg_d = 1'b0;
        end else begin
          a_d   = a_q[WIDTH-1] ? (~a_q + 1'b1) : a_q;
          b_d   = b_q[WIDTH-1] ? (~b_q + 1'b1) : b_q;
          neg_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        end
        prod_d  = '0;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        prod_d = {sum, prod_q[WIDTH-1:1]};
        b_d    = b_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (neg_q) prod_d = ~prod_q + 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write-port arbitration: the product owns the port in WB, the pipeline otherwise
  always_comb begin
    ready            = (state_q == S_IDLE);
    busy             = (state_q != S_IDLE);
    done             = (state_q == S_WB);
    rf_write_enable  = wb_we;
    rf_mul           = 2'b00;
    rf_write_address = wb_addr;
    rf_write_data_1  = wb_data;
    rf_write_data_2  = '0;
    wb_stall         = 1'b0;
    if (state_q == S_WB) begin
      rf_write_enable  = 1'b1;
      rf_mul           = (op_q == OP_MADD) ? 2'b10 : 2'b01;
      rf_write_address = '0;
      rf_write_data_1  = prod_q[WIDTH-1:0];
      rf_write_data_2  = prod_q[2*WIDTH-1:WIDTH];
      wb_stall         = wb_we;
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - scoreboard bench for mul_sequencer
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        ready, busy, done;
  logic        wb_we;
  logic [31:0] wb_addr, wb_data;
  logic        wb_stall;
  logic        rf_write_enable;
  logic [1:0]  rf_mul;
  logic [31:0] rf_write_address, rf_write_data_1, rf_write_data_2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  mul;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t exp_q[$];

  mul_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .ready(ready), .busy(busy), .done(done),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .rf_write_enable(rf_write_enable), .rf_mul(rf_mul),
    .rf_write_address(rf_write_address),
    .rf_write_data_1(rf_write_data_1), .rf_write_data_2(rf_write_data_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every product write on the port is matched against the scoreboard
  exp_t m;
  always @(negedge clk) begin
    if (rst === 1'b0 && rf_mul !== 2'b00) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rf_mul %0h hi %0h lo %0h expected no write",
                 rf_mul, rf_write_data_2, rf_write_data_1);
      end else begin
        m = exp_q.pop_front();
        chk("wb_rf_mul", rf_mul, m.mul);
        chk("wb_hi", rf_write_data_2, m.hi);
        chk("wb_lo", rf_write_data_1, m.lo);
        chk("wb_addr0", rf_write_address, 0);
        chk("wb_we_done", {rf_write_enable, done}, 2'b11);
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] emul, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit pipe, input bit inject);
    int n;
    exp_t e;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_before_start", ready, 1);
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (pipe) begin
      wb_we = 1'b1; wb_addr = 32'd8; wb_data = 32'h55;
    end
    e.mul = emul; e.hi = ehi; e.lo = elo;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; op = 2'b00;
    chk("busy_after_accept", {ready, busy}, 2'b01);
    if (pipe) chk("pipe_pass_busy", {rf_write_enable, rf_mul, wb_stall}, {1'b1, 2'b00, 1'b0});
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk); #1; n++;
      if (inject && n == 9) begin
        start = 1'b1; op = 2'b01; src_a = 32'h1234; src_b = 32'd5;
      end else begin
        start = 1'b0; op = 2'b00;
      end
    end
    start = 1'b0;
    chk("wb_latency", n, 34);
    if (pipe) chk("wb_stall_in_wb", wb_stall, 1);
    @(posedge clk); #1;
    chk("done_pulse_end", {done, ready, busy}, 3'b010);
    if (pipe) begin
      chk("pipe_retry_ctl", {rf_write_enable, rf_mul, wb_stall}, {1'b1, 2'b00, 1'b0});
      chk("pipe_retry_addr", rf_write_address, 8);
      chk("pipe_retry_data", {rf_write_data_2, rf_write_data_1}, 64'h0000_0000_0000_0055);
      wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", {ready, busy, done, wb_stall}, 4'b1000);
    chk("reset_rf_ctl", {rf_write_enable, rf_mul}, 3'b000);
    chk("reset_rf_data", {rf_write_data_2, rf_write_data_1}, 64'h0);
    chk("reset_rf_addr", rf_write_address, 0);
    rst = 1'b0;

    // Pipeline write passes straight through while idle
    wb_we = 1'b1; wb_addr = 32'd3; wb_data = 32'habc;
    #1;
    chk("idle_pass_ctl", {rf_write_enable, rf_mul, wb_stall}, {1'b1, 2'b00, 1'b0});
    chk("idle_pass_addr", rf_write_address, 3);
    chk("idle_pass_data", {rf_write_data_2, rf_write_data_1}, 64'h0000_0000_0000_0abc);
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;

    run_op(2'b01, 32'd7,         32'hFFFFFFFD, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
    run_op(2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF, 2'b01, 32'hFFFFFFFE, 32'h00000001, 0, 0);
    run_op(2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF, 2'b01, 32'h00000000, 32'h00000001, 0, 0);
    run_op(2'b01, 32'h80000000,  32'h80000000, 2'b01, 32'h40000000, 32'h00000000, 0, 0);
    run_op(2'b10, 32'd2,         32'd3,        2'b10, 32'h00000000, 32'h00000006, 1, 0);
    run_op(2'b01, 32'd0,         32'hFFFFFFFB, 2'b01, 32'h00000000, 32'h00000000, 0, 0);
    run_op(2'b01, 32'hFFFFFFFE,  32'h7FFFFFFF, 2'b01, 32'hFFFFFFFF, 32'h00000002, 0, 0);
    run_op(2'b10, 32'hFFFFFFFF,  32'd5,        2'b10, 32'hFFFFFFFF, 32'hFFFFFFFB, 0, 1);

    // Invalid opcode is ignored in IDLE
    start = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    chk("op00_ignored", {ready, busy}, 2'b10);
    repeat (40) @(posedge clk);
    #1;
    chk("op00_still_idle", {ready, busy, done}, 3'b100);

    // Reset in the middle of RUN aborts without a write
    start = 1'b1; op = 2'b01; src_a = 32'd7; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 2'b00;
    repeat (19) @(posedge clk);
    #1;
    chk("busy_before_abort", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_flags", {ready, busy, done, wb_stall}, 4'b1000);
    chk("abort_rf_ctl", {rf_write_enable, rf_mul}, 3'b000);
    chk("abort_rf_data", {rf_write_data_2, rf_write_data_1}, 64'h0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_stays_idle", {ready, busy}, 2'b10);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Multi-cycle shift-add multiplier controller that owns the register file's write port. It sequences 32x32 MULT, MULTU and MADD operations into a 64-bit product, then writes the product into HI/LO through the register file's mul-mode write interface. It also arbitrates that single write port between the product writeback and the pipeline's ordinary GPR writeback. It sits between the execute/writeback stages and the register file.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH bits and the iteration count is WIDTH.

Ports:
clk  input  1  clock.
rst  input  1  synchronous active-high reset.
start  input  1  operation request; sampled only in IDLE.
op  input  2  operation code: 01 MULT (signed, load HI/LO); 10 MADD (signed, accumulate into HI/LO); 11 MULTU (unsigned, load HI/LO); 00 invalid, ignored.
src_a  input  WIDTH  multiplicand (rs).
src_b  input  WIDTH  multiplier (rt).
ready  output  1  high in IDLE only.
busy  output  1  high in every non-IDLE state.
done  output  1  one-cycle pulse in the WB state.
wb_we  input  1  pipeline GPR write request.
wb_addr  input  32  pipeline GPR write address.
wb_data  input  32  pipeline GPR write data.
wb_stall  output  1  pipeline write was not accepted this cycle; hold the request.
rf_write_enable  output  1  to register file write_enable.
rf_mul  output  2  to register file mul.
rf_write_address  output  32  to register file write_address.
rf_write_data_1  output  32  to register file write_data_1 (LO part).
rf_write_data_2  output  32  to register file write_data_2 (HI part).

Behaviour:
- Reset: state=IDLE, counter=0, product/multiplicand/multiplier/sign registers=0. Outputs: ready=1, busy=0, done=0, wb_stall=0, rf_write_enable=0, rf_mul=0, all rf data and address outputs 0. Reset in any state aborts the operation; no HI/LO write occurs.
- States: IDLE -> PREP -> RUN -> FIX -> WB -> IDLE.
- IDLE: when start=1 and op is not 00, latch op, src_a and src_b, then go to PREP. When start=1 and op=00, stay in IDLE. A start in any other state is ignored.
- PREP (1 cycle), signed ops: store |src_a| and |src_b|, and neg = sign(a) XOR sign(b). MULTU: store the operands raw with neg=0. Clear the product and counter.
- RUN (WIDTH cycles):
  - If the multiplier LSB is 1, add the multiplicand to the upper half of the product, keeping the carry.
  - Shift the {carry, product} register right by 1 and shift the multiplier right by 1.
  - Increment the counter. Leave RUN when counter==WIDTH-1 is processed.
- The magnitude of 0x80000000 is 2^31. This is handled by treating the magnitude as unsigned.
- FIX (1 cycle): if neg=1, product = two's-complement negation over 2*WIDTH bits.
- WB (1 cycle):
  - rf_write_enable=1, rf_mul=01 for MULT/MULTU or 10 for MADD.
  - rf_write_data_2 = product[63:32], rf_write_data_1 = product[31:0], rf_write_address=0. MADD accumulation is performed by the register file.
  - done=1. Next state is IDLE.
- Latency: start accepted at edge E0 gives PREP in cycle 1, RUN in cycles 2-33, FIX in cycle 34, WB in cycle 35. busy=1 in cycles 1-35; ready=1 again in cycle 36.
- Arbitration (combinational outputs):
  - Outside WB: rf_write_enable=wb_we, rf_mul=00, rf_write_address=wb_addr, rf_write_data_1=wb_data, rf_write_data_2=0, wb_stall=0.
  - In WB: the product write wins. wb_stall=wb_we and the pipeline write is dropped for that cycle. The pipeline must re-present it, and it passes in the next cycle.
- No state other than WB ever drives rf_mul to a non-zero value.
- Back-to-back operations: a start in the cycle immediately after WB (IDLE) is accepted.

Test Plan:
- MULT src_a=7, src_b=0xFFFFFFFD (-3) -> WB at cycle 35: rf_mul=01, data_2=0xFFFFFFFF, data_1=0xFFFFFFEB, done=1 for exactly 1 cycle.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> data_2=0xFFFFFFFE, data_1=0x00000001. MULT with the same operands -> data_2=0, data_1=1.
- MULT 0x80000000 x 0x80000000 -> data_2=0x40000000, data_1=0. MADD 2 x 3 -> rf_mul=10, data_2=0, data_1=6.
- wb_we=1, wb_addr=8, wb_data=0x55 held across WB:
  - In WB: wb_stall=1 and rf carries the product.
  - Next cycle: rf_write_enable=1, rf_mul=00, address 8, data 0x55, wb_stall=0.
- Second start with op=01 at cycle 10 of a running operation -> ignored. The single WB carries the first operation's result. op=00 with start in IDLE -> no state change.
- rst=1 in RUN (cycle 20) -> next cycle IDLE, ready=1, all outputs at reset values. No rf_mul!=00 write occurs afterwards.
